// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences weight load, row streaming and result drain
// for a SIZE x SIZE weight-stationary array, with input skew and output de-skew.
module systolic_scheduler #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 10,
    parameter int ARR_LAT = 10,
    parameter int AW      = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  wt_load,
    output logic [AW-1:0]         wt_row,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [SIZE*WIDTH-1:0] rd_data,
    output logic [SIZE-1:0]       feed_valid,
    output logic [SIZE*WIDTH-1:0] feed_data,
    input  logic [SIZE*WIDTH-1:0] arr_out,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [SIZE*WIDTH-1:0] wr_data
);

    // Read strobe to write strobe: 1 read latency + max skew + array latency
    localparam int            VDEPTH = SIZE + ARR_LAT;
    localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_cnt;
    logic [AW-1:0]         r_wcnt;
    logic [VDEPTH-1:0]     r_vpipe;
    logic                  w_flush;
    logic                  w_cnt_last;
    logic                  w_wr_en;
    logic                  w_wr_last;
    logic [SIZE*WIDTH-1:0] w_aligned;

    assign w_flush    = abort && (r_state != S_IDLE);
    assign w_cnt_last = (r_cnt == LAST);
    assign w_wr_en    = r_vpipe[VDEPTH-1];
    assign w_wr_last  = w_wr_en && (r_wcnt == LAST);

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        wt_load = 1'b0;
        wt_row  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WLOAD;
            end
            S_WLOAD: begin
                busy    = 1'b1;
                wt_load = 1'b1;
                wt_row  = r_cnt;
                if (w_cnt_last) w_next = S_STREAM;
            end
            S_STREAM: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = r_cnt;
                if (w_cnt_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_wr_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((wt_load || rd_en) && !w_cnt_last && !w_flush) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vpipe <= '0;
            r_wcnt  <= '0;
        end else if (w_flush) begin
            r_vpipe <= '0;
            r_wcnt  <= '0;
        end else begin
            r_vpipe <= {r_vpipe[VDEPTH-2:0], rd_en};
            if (w_wr_en) begin
                r_wcnt <= w_wr_last ? '0 : r_wcnt + 1'b1;
            end
        end
    end

    // Lane j valid is rd_en delayed j+1, matching its skew depth
    assign feed_valid = r_vpipe[SIZE-1:0];

    for (genvar j = 0; j < SIZE; j++) begin : g_skew
        if (j == 0) begin : g_pass
            assign feed_data[WIDTH-1:0] =
                r_vpipe[0] ? rd_data[WIDTH-1:0] : '0;
        end else begin : g_dly
            logic [WIDTH-1:0] r_d [j];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < j; k++) r_d[k] <= '0;
                end else if (w_flush) begin
                    for (int k = 0; k < j; k++) r_d[k] <= '0;
                end else begin
                    r_d[0] <= rd_data[j*WIDTH +: WIDTH];
                    for (int k = 1; k < j; k++) r_d[k] <= r_d[k-1];
                end
            end

            assign feed_data[j*WIDTH +: WIDTH] =
                r_vpipe[j] ? r_d[j-1] : '0;
        end
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_deskew
        if (j == SIZE - 1) begin : g_pass
            assign w_aligned[j*WIDTH +: WIDTH] = arr_out[j*WIDTH +: WIDTH];
        end else begin : g_dly
            localparam int D = SIZE - 1 - j;
            logic [WIDTH-1:0] r_q [D];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) r_q[k] <= '0;
                end else if (w_flush) begin
                    for (int k = 0; k < D; k++) r_q[k] <= '0;
                end else begin
                    r_q[0] <= arr_out[j*WIDTH +: WIDTH];
                    for (int k = 1; k < D; k++) r_q[k] <= r_q[k-1];
                end
            end

            assign w_aligned[j*WIDTH +: WIDTH] = r_q[D-1];
        end
    end

    assign wr_en   = w_wr_en;
    assign wr_addr = w_wr_en ? r_wcnt : '0;
    assign wr_data = w_wr_en ? w_aligned : '0;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler: random matrices, a delay-plus-offset array
// model, and a per-cycle timeline reference derived from the start edge.
`timescale 1ns/1ps
module tb_systolic_scheduler;

    localparam int WIDTH   = 16;
    localparam int SIZE    = 10;
    localparam int ARR_LAT = 10;
    localparam int AW      = $clog2(SIZE);
    localparam int DW      = SIZE * WIDTH;
    localparam int T_DONE  = 2 * SIZE + ARR_LAT;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            wt_load;
    logic [AW-1:0]   wt_row;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [SIZE-1:0] feed_valid;
    logic [DW-1:0]   feed_data;
    logic [DW-1:0]   arr_out;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    logic [DW-1:0] mem [SIZE];
    logic [DW-1:0] hist [ARR_LAT];
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] rnd_rd;
    logic [DW-1:0] rnd_arr;
    logic [DW-1:0] arr_model;
    logic          use_rand;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_done;

    always #5 clk = ~clk;

    systolic_scheduler #(
        .WIDTH(WIDTH), .SIZE(SIZE), .ARR_LAT(ARR_LAT), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .wt_load(wt_load), .wt_row(wt_row),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .feed_valid(feed_valid), .feed_data(feed_data),
        .arr_out(arr_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign rd_data = use_rand ? rnd_rd : mem_q;
    assign arr_out = use_rand ? rnd_arr : arr_model;

    // Input buffer: one cycle read latency
    always @(posedge clk) begin
        if (rd_en) mem_q <= mem[int'(rd_addr)];
    end

    // Array model: each lane delayed by ARR_LAT, plus 1000
    always @(posedge clk) begin
        hist[0] <= feed_data;
        for (int k = 1; k < ARR_LAT; k++) hist[k] <= hist[k-1];
    end

    always @* begin
        arr_model = '0;
        for (int j = 0; j < SIZE; j++)
            arr_model[j*WIDTH +: WIDTH] =
                hist[ARR_LAT-1][j*WIDTH +: WIDTH] + WIDTH'(1000);
    end

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < SIZE; j++) v[j*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] elem(input int r, input int c);
        return mem[r][c*WIDTH +: WIDTH];
    endfunction

    function automatic logic [DW-1:0] obs_ctrl();
        return DW'({busy, done, wt_load, wt_row, rd_en, rd_addr,
                    feed_valid, wr_en, wr_addr});
    endfunction

    task automatic chk(input string tag, input int tau,
                       input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s tau=%0d observed=%h expected=%h",
                   tag, tau, obs, exp);
        end
    endtask

    // Expected outputs for the cycle tau cycles after the first STREAM cycle
    task automatic chk_cycle(input int tau);
        logic [DW-1:0]   e_feed;
        logic [DW-1:0]   e_wr;
        logic [SIZE-1:0] e_fv;
        logic            e_busy, e_done, e_wl, e_rd, e_we;
        logic [AW-1:0]   e_wrow, e_raddr, e_waddr;
        e_busy  = (tau >= -SIZE) && (tau <= T_DONE);
        e_done  = (tau == T_DONE);
        e_wl    = (tau >= -SIZE) && (tau < 0);
        e_wrow  = e_wl ? AW'(tau + SIZE) : '0;
        e_rd    = (tau >= 0) && (tau < SIZE);
        e_raddr = e_rd ? AW'(tau) : '0;
        e_fv    = '0;
        e_feed  = '0;
        for (int j = 0; j < SIZE; j++) begin
            int r = tau - 1 - j;
            if (r >= 0 && r < SIZE) begin
                e_fv[j] = 1'b1;
                e_feed[j*WIDTH +: WIDTH] = elem(r, j);
            end
        end
        e_we    = (tau >= SIZE + ARR_LAT) && (tau < T_DONE);
        e_waddr = e_we ? AW'(tau - SIZE - ARR_LAT) : '0;
        e_wr    = '0;
        if (e_we)
            for (int j = 0; j < SIZE; j++)
                e_wr[j*WIDTH +: WIDTH] =
                    elem(tau - SIZE - ARR_LAT, j) + WIDTH'(1000);
        chk("ctrl", tau, obs_ctrl(),
            DW'({e_busy, e_done, e_wl, e_wrow, e_rd, e_raddr,
                 e_fv, e_we, e_waddr}));
        chk("feed", tau, feed_data, e_feed);
        chk("wr", tau, wr_data, e_wr);
    endtask

    // Caller raises start just before edge s; runs through the IDLE cycle after done
    task automatic run_pass(input bit midpulse, input bit hold, input bit skewck);
        n_done = 0;
        for (int k = 1; k <= T_DONE + SIZE + 2; k++) begin
            int tau;
            @(negedge clk);
            tau = k - SIZE - 1;
            chk_cycle(tau);
            if (done) n_done++;
            if (skewck) begin
                if (tau == 4)  chk("lane3_r0", tau, DW'(feed_data[3*WIDTH +: WIDTH]), DW'(3));
                if (tau == 5)  chk("lane3_r1", tau, DW'(feed_data[3*WIDTH +: WIDTH]), DW'(13));
                if (tau == 19) chk("lane9_r9", tau, DW'(feed_data[9*WIDTH +: WIDTH]), DW'(99));
                if (tau == 11) chk("lane0_end", tau,
                                   DW'({feed_valid[0], feed_data[WIDTH-1:0]}), DW'(0));
            end
            if (k == 1) start = 1'b0;
            if (midpulse && tau == 5) start = 1'b1;
            if (midpulse && tau == 6) start = 1'b0;
            if (hold && tau == 25) start = 1'b1;
        end
        chk("done_cnt", T_DONE, DW'(n_done), DW'(1));
    endtask

    task automatic load_random();
        for (int r = 0; r < SIZE; r++) mem[r] = rand_row();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        use_rand = 1'b1;
        rnd_rd   = rand_row();
        rnd_arr  = rand_row();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c*WIDTH +: WIDTH] = WIDTH'(r * 10 + c);
        #1 rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            start   = 1'($urandom);
            abort   = 1'($urandom);
            rnd_rd  = rand_row();
            rnd_arr = rand_row();
            @(negedge clk);
            chk("rst_ctrl", i, obs_ctrl(), '0);
            chk("rst_feed", i, feed_data, '0);
            chk("rst_wr", i, wr_data, '0);
        end
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        use_rand = 1'b0;
        repeat (2) @(negedge clk);

        // Directed matrix, stray start mid-pass, start held into the next pass
        start = 1'b1;
        run_pass(1'b1, 1'b1, 1'b1);
        load_random();
        run_pass(1'b0, 1'b0, 1'b0);

        // Abort during STREAM
        load_random();
        start = 1'b1;
        for (int k = 1; k <= SIZE + 4; k++) begin
            int tau;
            @(negedge clk);
            tau = k - SIZE - 1;
            chk_cycle(tau);
            if (k == 1) start = 1'b0;
            if (tau == 3) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 4, obs_ctrl(), '0);
        chk("abort_feed", 4, feed_data, '0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_quiet", 5 + i, DW'({wr_en, done, busy}), '0);
        end
        load_random();
        start = 1'b1;
        run_pass(1'b0, 1'b0, 1'b0);

        // Asynchronous reset during DRAIN
        load_random();
        start = 1'b1;
        for (int k = 1; k <= SIZE + 23; k++) begin
            int tau;
            @(negedge clk);
            tau = k - SIZE - 1;
            chk_cycle(tau);
            if (k == 1) start = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        chk("arst_ctrl", 22, obs_ctrl(), '0);
        chk("arst_feed", 22, feed_data, '0);
        chk("arst_wr", 22, wr_data, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("arst_quiet", 23 + i, DW'({wr_en, done, busy}), '0);
        end

        load_random();
        start = 1'b1;
        run_pass(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_scheduler.md
# systolic_scheduler

Sequencer that runs one full matrix pass through the 10x10 weight-stationary systolic array. On `start` it loads the weight rows, reads the input matrix row by row from a row-wide buffer, applies the diagonal input skew, de-skews the array's column outputs, writes aligned result rows back, and then pulses `done`. It sits between the matrix buffers and the `systolic_array` datapath and replaces ad-hoc start/done sequencing around it.

## Interface
- `WIDTH`, 16: signed element width.
- `SIZE`, 10: array dimension (rows = columns = lanes).
- `ARR_LAT`, 10: cycles from a lane-j feed element entering the array to its column-j result appearing on `arr_out`.
- `AW`, $clog2(SIZE): row address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a pass; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the current pass.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle pulse when the last result row has been written.
- `wt_load` out 1: weight-row load strobe to the array.
- `wt_row` out AW: index of the weight row being loaded.
- `rd_en` out 1: input buffer read strobe.
- `rd_addr` out AW: input row index.
- `rd_data` in SIZE*WIDTH: input row data, valid 1 cycle after `rd_en`; lane j = bits [j*WIDTH +: WIDTH].
- `feed_valid` out SIZE: per-lane valid to the array row inputs.
- `feed_data` out SIZE*WIDTH: skewed lane data. A lane is 0 when its valid bit is low.
- `arr_out` in SIZE*WIDTH: raw column outputs from the array.
- `wr_en` out 1: result row write strobe.
- `wr_addr` out AW: result row index.
- `wr_data` out SIZE*WIDTH: de-skewed result row.

## Operation
- States: IDLE, WLOAD, STREAM, DRAIN, DONE.
- **IDLE**
  - If `start`=1 at a clock edge, go to WLOAD.
  - `start` is ignored in all other states.
- **WLOAD**
  - Lasts SIZE cycles.
  - `wt_load`=1 and `wt_row` counts 0..SIZE-1.
  - Then go to STREAM.
- **STREAM**
  - Lasts SIZE cycles.
  - `rd_en`=1 and `rd_addr` counts 0..SIZE-1.
  - Then go to DRAIN.
- **Input skew**
  - Lane j of the row read at cycle c drives `feed_data` lane j at cycle c+1+j, with `feed_valid[j]`=1.
  - Use a triangular register chain: lane j has j stages after the rd_data capture.
- **Output de-skew**
  - `arr_out` lane j is delayed by SIZE-1-j cycles, so all lanes of result row r align.
  - An internal valid pipeline of depth 1+(SIZE-1)+ARR_LAT, tracking `rd_en`, drives `wr_en`.
  - A result row counter drives `wr_addr`.
- **DRAIN**
  - Waits until the result row counter has written row SIZE-1.
  - Then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **abort**
  - `abort`=1 in any non-IDLE state moves to IDLE at the next edge.
  - Skew and valid pipelines are cleared, so no `wr_en` or `done` follows.
  - `abort` has priority over every other transition.
- No arithmetic is performed on data. It is a pure data move and is bit-exact.

## Timing
- **Reset values** (asynchronous, `rst`=0): every output is 0, state is IDLE, all counters, skew and de-skew registers are 0.
- **Timeline.** `start` is sampled at edge s.
  - WLOAD occupies cycles s+1..s+SIZE.
  - t0 = s+SIZE+1 is the first STREAM cycle (`rd_addr`=0).
  - Row r is read at t0+r.
  - Lane j of row r is fed at t0+1+r+j.
  - Result row r is written at t0+r+SIZE+ARR_LAT.
  - `done` is asserted at t0+2*SIZE+ARR_LAT.
  - `busy` falls at t0+2*SIZE+ARR_LAT+1.
- **Default latency:** `start` edge to `done` = 2*SIZE+ARR_LAT+SIZE+1 = 41 cycles.
- **Back-to-back:** `start` held high keeps running. `start`=1 in the IDLE cycle after DONE begins a new pass, with no extra gap.
- **Reset mid-pass:** immediate return to reset values. `done` is not asserted for the interrupted pass.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with random inputs.
  - `busy`, `done`, `wt_load`, `rd_en`, `wr_en` and `feed_valid` are all 0.
  - `feed_data` and `wr_data` are 0.
- **Skew check.** Drive `rd_data` so that A[r][c] = r*10+c.
  - Lane 3 shows 3 at t0+4 and 13 at t0+5.
  - Lane 9 shows 99 at t0+19.
  - Lane 0 is 0 with `feed_valid[0]`=0 at t0+11.
- **Full pass with a behavioural array model.** The model returns lane j delayed by ARR_LAT and adds 1000 per lane.
  - `wr_addr` runs 0..9 at t0+20..t0+29, with row r = A[r][c]+1000.
  - `done` is high only at t0+30.
- **Start during busy.** Pulse `start` at t0+5: no effect, `done` count stays 1. Then hold `start` high through the end.
  - A second pass begins with `wt_load` at the cycle after `done`+1.
- **Abort.** Assert `abort` at t0+3.
  - IDLE at t0+4.
  - `wr_en` and `done` stay 0 for the next 40 cycles.
  - A following `start` produces a correct full pass.
- **Async reset in DRAIN.** Drop `rst` at t0+22 between clock edges.
  - Outputs go to 0 without waiting for a clock edge.
  - No further `wr_en`, and no `done`.
